// File: rtl/frame_diff_encoder_gen.sv
// Framer plus differential encoder for the DPSK transmit path: gathers DATA_WORDS
// input words, prepends a header and streams d[n] = d[n-1] ^ b[n] with valid/ready.
//
// state   | meaning
// COLLECT | accepting input words into the frame buffer, output idle
// SEND    | serialising header and data bits, in_ready held low
module frame_diff_encoder_gen #(
    parameter int                DATA_W       = 8,
    parameter int                DATA_WORDS   = 4,
    parameter int                HEAD_LEN     = 16,
    parameter logic [HEAD_LEN-1:0] HEAD_PATTERN = 16'hEB90,
    parameter bit                LSB_FIRST    = 1'b1,
    parameter bit                DIFF_INIT    = 1'b1,
    parameter bit                DIFF_RESTART = 1'b1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic [15:0]       frame_cnt
);

    localparam int FRAME_LEN = HEAD_LEN + DATA_W * DATA_WORDS;
    localparam int BW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CW        = $clog2(DATA_WORDS + 1);
    localparam int WI        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [BW-1:0] LAST_IDX  = BW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(DATA_WORDS - 1);

    typedef enum logic {COLLECT, SEND} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     wcnt, wcnt_nxt;
    logic [BW-1:0]     bidx, bidx_nxt, bidx_inc;
    logic              dstate, dstate_nxt;
    logic              out_data_nxt, out_valid_nxt, out_first_nxt, out_last_nxt;
    logic [15:0]       frame_cnt_nxt;
    logic [DATA_W-1:0] words [DATA_WORDS];
    logic [FRAME_LEN-1:0] raw;
    logic              accept, xfer;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid & in_ready;
    assign xfer     = (state == SEND) & out_valid & out_ready;
    assign bidx_inc = bidx + 1'b1;

    // raw[n] is frame bit b[n] in transmission order
    always_comb begin
        raw = '0;
        for (int h = 0; h < HEAD_LEN; h++)
            raw[h] = HEAD_PATTERN[HEAD_LEN-1-h];
        for (int k = 0; k < DATA_WORDS; k++)
            for (int j = 0; j < DATA_W; j++)
                raw[HEAD_LEN + k*DATA_W + j] = words[k][LSB_FIRST ? j : DATA_W-1-j];
    end

    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        bidx_nxt      = bidx;
        dstate_nxt    = dstate;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_first_nxt = out_first;
        out_last_nxt  = out_last;
        frame_cnt_nxt = frame_cnt;
        case (state)
            COLLECT: begin
                if (accept) begin
                    wcnt_nxt = wcnt + 1'b1;
                    if (wcnt == LAST_WORD) begin
                        // b[0] is always a header bit, so d[0] is ready without the new word
                        state_nxt     = SEND;
                        bidx_nxt      = '0;
                        out_valid_nxt = 1'b1;
                        out_first_nxt = 1'b1;
                        out_last_nxt  = (FRAME_LEN == 1);
                        out_data_nxt  = (DIFF_RESTART ? DIFF_INIT : dstate) ^ raw[0];
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    out_first_nxt = 1'b0;
                    if (bidx == LAST_IDX) begin
                        state_nxt     = COLLECT;
                        wcnt_nxt      = '0;
                        dstate_nxt    = out_data;
                        out_data_nxt  = 1'b0;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                    end else begin
                        bidx_nxt      = bidx_inc;
                        out_data_nxt  = out_data ^ raw[bidx_inc];
                        out_last_nxt  = (bidx_inc == LAST_IDX);
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= COLLECT;
            wcnt      <= '0;
            bidx      <= '0;
            dstate    <= DIFF_INIT;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            bidx      <= bidx_nxt;
            dstate    <= dstate_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_first <= out_first_nxt;
            out_last  <= out_last_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept)
            words[wcnt[WI-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_frame_diff_encoder_gen.sv
// Directed bench for frame_diff_encoder_gen: golden 8-bit frames in two bit orders,
// carried-over diff state, backpressure, input handshake and mid-frame reset.
module tb_frame_diff_encoder_gen;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst;

    logic [7:0]  d_in_data;
    logic        d_in_valid, d_in_ready, d_out_data, d_out_valid, d_out_ready;
    logic        d_out_first, d_out_last;
    logic [15:0] d_frame_cnt;

    logic [3:0]  g_in_data   [3];
    logic        g_in_valid  [3];
    logic        g_in_ready  [3];
    logic        g_out_data  [3];
    logic        g_out_valid [3];
    logic        g_out_ready [3];
    logic        g_out_first [3];
    logic        g_out_last  [3];
    logic [15:0] g_frame_cnt [3];

    frame_diff_encoder_gen u_def (
        .sys_clk(sys_clk), .rst(rst),
        .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_first(d_out_first), .out_last(d_out_last), .frame_cnt(d_frame_cnt)
    );

    frame_diff_encoder_gen #(.DATA_W(4), .DATA_WORDS(1), .HEAD_LEN(4), .HEAD_PATTERN(4'b1011),
        .LSB_FIRST(1'b1), .DIFF_INIT(1'b1), .DIFF_RESTART(1'b1)) u_g1 (
        .sys_clk(sys_clk), .rst(rst),
        .in_data(g_in_data[0]), .in_valid(g_in_valid[0]), .in_ready(g_in_ready[0]),
        .out_data(g_out_data[0]), .out_valid(g_out_valid[0]), .out_ready(g_out_ready[0]),
        .out_first(g_out_first[0]), .out_last(g_out_last[0]), .frame_cnt(g_frame_cnt[0])
    );

    frame_diff_encoder_gen #(.DATA_W(4), .DATA_WORDS(1), .HEAD_LEN(4), .HEAD_PATTERN(4'b1011),
        .LSB_FIRST(1'b0), .DIFF_INIT(1'b1), .DIFF_RESTART(1'b1)) u_g0 (
        .sys_clk(sys_clk), .rst(rst),
        .in_data(g_in_data[1]), .in_valid(g_in_valid[1]), .in_ready(g_in_ready[1]),
        .out_data(g_out_data[1]), .out_valid(g_out_valid[1]), .out_ready(g_out_ready[1]),
        .out_first(g_out_first[1]), .out_last(g_out_last[1]), .frame_cnt(g_frame_cnt[1])
    );

    frame_diff_encoder_gen #(.DATA_W(4), .DATA_WORDS(1), .HEAD_LEN(4), .HEAD_PATTERN(4'b1011),
        .LSB_FIRST(1'b1), .DIFF_INIT(1'b1), .DIFF_RESTART(1'b0)) u_nr (
        .sys_clk(sys_clk), .rst(rst),
        .in_data(g_in_data[2]), .in_valid(g_in_valid[2]), .in_ready(g_in_ready[2]),
        .out_data(g_out_data[2]), .out_valid(g_out_valid[2]), .out_ready(g_out_ready[2]),
        .out_first(g_out_first[2]), .out_last(g_out_last[2]), .frame_cnt(g_frame_cnt[2])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // expected d[n] at bit n for the default configuration, d[-1] = 1
    function automatic logic [47:0] model48(input logic [31:0] ws);
        logic [15:0] hp = 16'hEB90;
        logic [47:0] m  = '0;
        logic d = 1'b1;
        logic b;
        for (int n = 0; n < 48; n++) begin
            if (n < 16) b = hp[15-n];
            else        b = ws[8*((n-16)/8) + ((n-16)%8)];
            d    = d ^ b;
            m[n] = d;
        end
        return m;
    endfunction

    // one word into small instance c, capture 8 bits; cap[7] is the first bit out
    task automatic g_frame(input int c, input logic [3:0] w, output logic [7:0] cap);
        cap = '0;
        @(negedge sys_clk);
        chk("g_in_ready_idle", 64'(g_in_ready[c]), 64'(1));
        g_in_data[c]   = w;
        g_in_valid[c]  = 1'b1;
        g_out_ready[c] = 1'b1;
        @(negedge sys_clk);
        g_in_valid[c]  = 1'b0;
        for (int n = 0; n < 8; n++) begin
            chk("g_out_valid", 64'(g_out_valid[c]), 64'(1));
            chk("g_out_first", 64'(g_out_first[c]), 64'(n == 0));
            chk("g_out_last",  64'(g_out_last[c]),  64'(n == 7));
            chk("g_in_ready_send", 64'(g_in_ready[c]), 64'(0));
            cap[7-n] = g_out_data[c];
            @(negedge sys_clk);
        end
        chk("g_out_valid_end", 64'(g_out_valid[c]), 64'(0));
        chk("g_in_ready_end",  64'(g_in_ready[c]),  64'(1));
    endtask

    task automatic d_put(input logic [7:0] w);
        d_in_data  = w;
        d_in_valid = 1'b1;
        @(negedge sys_clk);
        d_in_valid = 1'b0;
    endtask

    task automatic d_capture(output logic [47:0] cap, output int xf);
        cap = '0;
        xf  = 0;
        d_out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && xf < 48; cyc++) begin
            if (d_out_valid) begin
                cap[xf] = d_out_data;
                xf++;
            end
            @(negedge sys_clk);
        end
    endtask

    typedef struct {
        int         cfg;
        logic [3:0] word;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [7:0]  cap8;
        logic [47:0] cap48;
        logic [31:0] bp_w;
        logic [47:0] bp_exp;
        logic [7:0]  hw [6];
        int          exp_cnt [2];
        int          xf, idx, low, idx_at_drop;
        logic        rdy, stalled, p_data, p_first, p_last;

        tbl[0] = '{0, 4'b0110, 8'b00100100};
        tbl[1] = '{0, 4'b0000, 8'b00100000};
        tbl[2] = '{0, 4'b1111, 8'b00101010};
        tbl[3] = '{0, 4'b0001, 8'b00101111};
        tbl[4] = '{0, 4'b1000, 8'b00100001};
        tbl[5] = '{1, 4'b0110, 8'b00100100};
        tbl[6] = '{1, 4'b0001, 8'b00100001};
        tbl[7] = '{1, 4'b1000, 8'b00101111};
        tbl[8] = '{1, 4'b1010, 8'b00101100};

        rst = 1'b1;
        d_in_data = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            g_in_data[c] = '0; g_in_valid[c] = 1'b0; g_out_ready[c] = 1'b0;
        end
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        chk("rst_in_ready",  64'(d_in_ready),  64'(1));
        chk("rst_out_valid", 64'(d_out_valid), 64'(0));
        chk("rst_out_data",  64'(d_out_data),  64'(0));
        chk("rst_out_first", 64'(d_out_first), 64'(0));
        chk("rst_out_last",  64'(d_out_last),  64'(0));
        chk("rst_frame_cnt", 64'(d_frame_cnt), 64'(0));
        chk("rst_g_frame_cnt", 64'(g_frame_cnt[0]), 64'(0));

        for (int i = 0; i < 9; i++) begin
            g_frame(tbl[i].cfg, tbl[i].word, cap8);
            chk("golden_stream", 64'(cap8), 64'(tbl[i].exp));
            exp_cnt[tbl[i].cfg]++;
            chk("golden_frame_cnt", 64'(g_frame_cnt[tbl[i].cfg]), 64'(exp_cnt[tbl[i].cfg]));
        end

        g_frame(2, 4'b0110, cap8);
        chk("carry_frame1", 64'(cap8), 64'(8'b00100100));
        g_frame(2, 4'b0110, cap8);
        chk("carry_frame2", 64'(cap8), 64'(8'b11011011));
        chk("carry_frame_cnt", 64'(g_frame_cnt[2]), 64'(2));

        // backpressure on the default configuration
        bp_w   = 32'h810F3CA5;
        bp_exp = model48(bp_w);
        for (int k = 0; k < 4; k++) d_put(bp_w[8*k +: 8]);
        cap48 = '0; xf = 0; stalled = 1'b0;
        p_data = 1'b0; p_first = 1'b0; p_last = 1'b0;
        for (int cyc = 0; cyc < 400 && xf < 48; cyc++) begin
            if (stalled) begin
                chk("bp_hold_data",  64'(d_out_data),  64'(p_data));
                chk("bp_hold_first", 64'(d_out_first), 64'(p_first));
                chk("bp_hold_last",  64'(d_out_last),  64'(p_last));
            end
            rdy = 1'($urandom_range(0, 1));
            d_out_ready = rdy;
            if (d_out_valid && rdy) begin
                chk("bp_first", 64'(d_out_first), 64'(xf == 0));
                chk("bp_last",  64'(d_out_last),  64'(xf == 47));
                cap48[xf] = d_out_data;
                xf++;
            end
            stalled = d_out_valid && !rdy;
            p_data = d_out_data; p_first = d_out_first; p_last = d_out_last;
            @(negedge sys_clk);
        end
        chk("bp_transfers", 64'(xf), 64'(48));
        chk("bp_stream", 64'(cap48), 64'(bp_exp));
        chk("bp_valid_after", 64'(d_out_valid), 64'(0));
        chk("bp_frame_cnt", 64'(d_frame_cnt), 64'(1));

        // in_valid held for six words: four accepted, two wait for the next frame
        hw[0] = 8'h11; hw[1] = 8'h22; hw[2] = 8'h33;
        hw[3] = 8'h44; hw[4] = 8'h55; hw[5] = 8'h66;
        d_out_ready = 1'b1;
        idx = 0; low = 0; idx_at_drop = -1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            rdy = d_in_ready;
            if (!rdy) begin
                low++;
                if (idx_at_drop < 0) idx_at_drop = idx;
            end
            if (idx < 6) begin
                d_in_data  = hw[idx];
                d_in_valid = 1'b1;
            end else begin
                d_in_valid = 1'b0;
            end
            if (rdy && idx < 6) idx++;
            @(negedge sys_clk);
        end
        d_in_valid = 1'b0;
        chk("hs_accepted_before_send", 64'(idx_at_drop), 64'(4));
        chk("hs_in_ready_low_cycles", 64'(low), 64'(48));
        chk("hs_total_accepted", 64'(idx), 64'(6));
        chk("hs_frame_cnt", 64'(d_frame_cnt), 64'(2));
        chk("hs_waiting_ready", 64'(d_in_ready), 64'(1));
        chk("hs_waiting_valid", 64'(d_out_valid), 64'(0));

        // complete the pending frame, then reset at bit 20
        d_put(8'h77);
        d_put(8'h88);
        xf = 0;
        for (int cyc = 0; cyc < 100 && xf < 20; cyc++) begin
            if (d_out_valid) xf++;
            @(negedge sys_clk);
        end
        chk("rm_reached_bit20", 64'(xf), 64'(20));
        chk("rm_valid_at_bit20", 64'(d_out_valid), 64'(1));
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        chk("rm_out_valid", 64'(d_out_valid), 64'(0));
        chk("rm_in_ready",  64'(d_in_ready),  64'(1));
        chk("rm_frame_cnt", 64'(d_frame_cnt), 64'(0));
        chk("rm_out_first", 64'(d_out_first), 64'(0));
        for (int k = 0; k < 4; k++) d_put(bp_w[8*k +: 8]);
        chk("rm_fresh_first", 64'(d_out_first), 64'(1));
        d_capture(cap48, xf);
        chk("rm_fresh_transfers", 64'(xf), 64'(48));
        chk("rm_fresh_stream", 64'(cap48), 64'(bp_exp));
        chk("rm_fresh_frame_cnt", 64'(d_frame_cnt), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_diff_encoder_gen.md
Name: frame_diff_encoder_gen

Overview:
Parametrised framer and differential encoder for the DPSK transmit path. It collects DATA_WORDS words of DATA_W bits from the UART side, prepends a configurable header pattern, and serialises the frame one bit at a time. Each bit is differentially encoded. A full valid/ready handshake on the output lets the downstream sample-rate FIFO or modulator apply backpressure. Compared with the fixed-width framer, it adds selectable bit order, selectable diff-state restart per frame, frame markers and a frame counter.

Parameters:
DATA_W, 8, width of one input word (1..32)
DATA_WORDS, 4, input words per frame (1..256)
HEAD_LEN, 16, header length in bits (1..64)
HEAD_PATTERN, 16'hEB90, header bits, HEAD_LEN wide, sent MSB first
LSB_FIRST, 1, 1 = each data word is sent bit 0 first; 0 = MSB first
DIFF_INIT, 1, reference bit d[-1] used at reset and at each frame restart
DIFF_RESTART, 1, 1 = diff state reloads DIFF_INIT at every frame start; 0 = diff state carries over from the previous frame's last output bit
Derived: FRAME_LEN = HEAD_LEN + DATA_W*DATA_WORDS

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous reset, active high
in_data  in  DATA_W  UART word
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a word this cycle
out_data  out  1  diff-encoded bit
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts a bit
out_first  out  1  high with the first bit of a frame
out_last  out  1  high with the last bit of a frame
frame_cnt  out  16  completed frames, wraps at 16'hFFFF->0

Behaviour:
- Reset (sync, rst high at a sys_clk edge): state=COLLECT, word count=0, bit index=0, diff state=DIFF_INIT, frame_cnt=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_first=0, out_last=0. rst overrides everything, including mid-frame; the partial frame is discarded and the buffer content is don't-care.
- COLLECT state:
  - in_ready=1 and out_valid=0.
  - A word is accepted when in_valid & in_ready. It is stored as word slot k, where k = arrival order 0..DATA_WORDS-1.
  - On the DATA_WORDS-th accept, the next state is SEND and in_ready=0 from the following cycle.
  - No word beyond DATA_WORDS is accepted per frame.
- Frame bit order: raw bit b[0..FRAME_LEN-1] is built as follows.
  - Header: HEAD_PATTERN[HEAD_LEN-1] down to [0].
  - Then word 0 .. word DATA_WORDS-1.
  - Within each word: bit 0 upward if LSB_FIRST=1, else bit DATA_W-1 downward.
- Diff encoding: d[n] = d[n-1] XOR b[n].
  - d[-1] = DIFF_INIT if DIFF_RESTART=1 or this is the first frame after reset.
  - Otherwise d[-1] = d[FRAME_LEN-1] of the previous frame.
- SEND state:
  - out_data, out_valid, out_first and out_last are registered.
  - Latency: out_valid rises on the cycle after the last word is accepted, with out_data=d[0] and out_first=1.
  - A bit transfers on out_valid & out_ready. After a transfer, the next cycle presents d[n+1].
  - While out_ready=0, out_data, out_first and out_last hold stable; no bit is skipped or repeated.
  - out_last=1 exactly with d[FRAME_LEN-1]; out_first=1 only with d[0]. If FRAME_LEN=1 both are high together (not reachable with the legal minimum parameters, but must not break).
  - When the last bit transfers: frame_cnt increments, and the next cycle has out_valid=0, in_ready=1, state COLLECT, word count=0.
  - Throughput: with out_ready held high, one bit per clock, FRAME_LEN consecutive cycles.
- The input is ignored in SEND (in_ready=0, in_valid don't-care). Output handshake signals are ignored in COLLECT.
- Widths: word count is $clog2(DATA_WORDS+1) bits; bit index is $clog2(FRAME_LEN) bits. No overflow is possible within the legal ranges.

Test Plan:
- Golden frame. Config: HEAD_LEN=4, HEAD_PATTERN=4'b1011, DATA_W=4, DATA_WORDS=1, LSB_FIRST=1, DIFF_INIT=1; input word 4'b0110, out_ready=1.
  - Required: out_data = 0,0,1,0,0,1,0,0 on 8 consecutive cycles.
  - out_first on bit 0, out_last on bit 7, frame_cnt 0->1.
- Same config with LSB_FIRST=0, word 4'b0110.
  - Raw bits 1,0,1,1,0,1,1,0 -> out_data = 0,0,1,0,0,1,0,0.
- Backpressure: default config; toggle out_ready randomly (about 50%).
  - Captured bit stream equals the golden model; out_data stable while out_valid & !out_ready.
  - Exactly 48 transfers per frame.
- DIFF_RESTART=0, golden config, two frames with word 4'b0110 each.
  - Second frame starts from d[-1]=0: out_data = 1,1,0,1,1,0,1,1.
  - frame_cnt=2.
- Input handshake:
  - In default config, in_valid held high for 6 words: only 4 are accepted. in_ready=0 during all 48 SEND cycles, then returns to 1 and words 5 and 6 are accepted for the next frame.
- Reset mid-frame: assert rst at bit 20 of SEND.
  - Next cycle: out_valid=0, in_ready=1, frame_cnt=0.
  - A fresh frame then matches the golden model with d[-1]=DIFF_INIT.
